stb_hash_ctrl: RTL and testbench
================================

// Module: stb_hash_ctrl
// PURPOSE
//  Streebog message-stage sequencer. Accepts 512-bit message blocks over valid/ready, pads the final block,
//  maintains the bit counter N, drives the Sigma accumulator (clear/valid/data), and issues compression
//  requests: g_N(h,m) per block, then g_0(h,N) and g_0(h,Sigma). Sits between input framing and the g core.
// PARAMETERS
//  BLK_W   512  block / Sigma / N width (bits)
//  CNT_W   64   implemented width of N; zero-extended to BLK_W on g_n_o
// PORTS
//  clk_i        in   1       clock
//  rstn_i       in   1       asynchronous active-low reset
//  start_i      in   1       begin new message (sampled in IDLE only)
//  msg_valid_i  in   1       message block valid
//  msg_ready_o  out  1       block accepted when valid&ready
//  msg_data_i   in   BLK_W   block; bit 0 = first message bit of block
//  msg_last_i   in   1       final block of message
//  msg_bits_i   in   10      valid bits in final block, 0..512 (ignored unless last)
//  sum_clear_o  out  1       1-cycle clear pulse to Sigma accumulator
//  sum_valid_o  out  1       1-cycle add strobe to Sigma accumulator
//  sum_data_o   out  BLK_W   addend (padded block)
//  sigma_i      in   BLK_W   accumulator result (valid 1 cycle after sum_valid_o)
//  g_req_o      out  1       1-cycle compression request
//  g_mode_o     out  2       G_MSG=0, G_FIN_N=1, G_FIN_S=2
//  g_data_o     out  BLK_W   compression operand; held stable until g_done_i
//  g_n_o        out  BLK_W   key-side N: current N for G_MSG, 0 for G_FIN_*
//  g_done_i     in   1       compression finished (valid from cycle after g_req_o)
//  busy_o       out  1       high in every state except IDLE
//  done_o       out  1       1-cycle pulse when final g_0(h,Sigma) completes
// BEHAVIOUR
//  - Reset: all outputs 0, N=0, state IDLE; reset mid-message aborts with no further pulses.
//  - FSM: IDLE, ACCEPT, WAIT_BLK, PAD_EMPTY, WAIT_PAD, FIN_N, WAIT_N, FIN_S, WAIT_S.
//  - IDLE: start_i -> sum_clear_o pulse next cycle, N<=0, go ACCEPT. start_i outside IDLE ignored.
//  - ACCEPT: msg_ready_o=1 (registered, only in ACCEPT). Handshake at cycle t -> at t+1 g_req_o=1,
//    g_mode_o=G_MSG, sum_valid_o=1, g_data_o=sum_data_o=block, g_n_o=N pre-update; ready drops at t+1.
//    * not last, or last & bits>=512: N<=N+512, go WAIT_BLK (flag full_last if last).
//    * last & bits k<512: block' = data[k-1:0] | (1<<k), bits above k zeroed; N<=N+k; go WAIT_PAD.
//    * k=0: block'=1 (bit 0 only). msg_bits_i>512 treated as 512.
//  - WAIT_BLK: g_done_i -> full_last ? PAD_EMPTY : ACCEPT.
//  - PAD_EMPTY: issue G_MSG with block'=1, N unchanged (+0), sum_valid_o pulse; go WAIT_PAD.
//  - WAIT_PAD: g_done_i -> FIN_N. FIN_N: g_req_o, G_FIN_N, g_data_o=N (zero-ext), g_n_o=0 -> WAIT_N.
//  - WAIT_N: g_done_i -> FIN_S. FIN_S: g_req_o, G_FIN_S, g_data_o=sigma_i latched, g_n_o=0 -> WAIT_S.
//  - WAIT_S: g_done_i -> done_o pulse same cycle as transition to IDLE.
//  - g_done_i outside WAIT_* ignored. N wraps mod 2^CNT_W. Sum strobes never overlap clear.
// STRUCTURE
//  - stb_pkg: BLK_W constant, g_mode_t enum (G_MSG/G_FIN_N/G_FIN_S), state_t enum.
//  - Sub-module stb_pad: combinational padding (data, k) -> padded block; reused by PAD_EMPTY with k=0.
//  - Single FSM + N counter + registered output bank in top.
// TESTING
//  - Reset mid-WAIT_BLK -> all outputs 0, IDLE; next start_i works normally.
//  - Empty message: start, last with bits=0 -> one G_MSG data=1,N=0; G_FIN_N data=0; G_FIN_S; done_o.
//  - 63-byte message (bits=504) -> padded bit 504 set, 505..511 zero; FIN_N data=504.
//  - Two full blocks, second last bits=512 -> G_MSG g_n 0 then 512, PAD_EMPTY g_n=1024, FIN_N data=1024, 3 sum strobes.
//  - Backpressure: delay g_done_i 20 cycles, msg_valid_i held -> msg_ready_o stays 0, g_data_o stable.
//  - start_i asserted while busy and stray g_done_i in ACCEPT -> no state change, no extra pulses.

Source files
------------

// File: rtl/stb_pkg.sv
// Shared constants and types for the Streebog message-stage sequencer.
package stb_pkg;

  localparam int BLK_W     = 512;               // block / Sigma / N operand width
  localparam int DEF_CNT_W = 64;                // implemented width of the bit counter N
  localparam int BITS_W    = 10;                // width of the final-block bit count (0..512)
  localparam int PAD_K_W   = $clog2(BLK_W);     // padding position, 0..BLK_W-1

  // Compression request kinds seen by the g core.
  typedef enum logic [1:0] {
    G_MSG   = 2'd0,
    G_FIN_N = 2'd1,
    G_FIN_S = 2'd2
  } g_mode_t;

  typedef enum logic [3:0] {
    IDLE,
    ACCEPT,
    WAIT_BLK,
    PAD_EMPTY,
    WAIT_PAD,
    FIN_N,
    WAIT_N,
    FIN_S,
    WAIT_S
  } state_t;

endpackage

// File: rtl/stb_pad.sv
// Final-block padding: keep the k valid message bits, set bit k, clear everything above.
// k = 0 yields the lone padding bit used for the extra empty block.
module stb_pad
  import stb_pkg::*;
(
  input  logic [BLK_W-1:0]   data,
  input  logic [PAD_K_W-1:0] k,
  output logic [BLK_W-1:0]   padded
);

  // Per-bit select: message bit below k, marker bit at k, zero above.
  always_comb begin
    // NOTE: assigning a default before the loop guarantees every bit is driven on
    // every path, so no latch can be inferred.
    padded = '0;
    for (int i = 0; i < BLK_W; i++) begin
      if (i < int'(k)) begin
        padded[i] = data[i];
      end else if (i == int'(k)) begin
        padded[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stb_hash_ctrl.sv
// Streebog message-stage sequencer: accepts blocks, pads the last one, keeps the
// bit counter N, drives the Sigma accumulator and issues g_N / g_0 requests.
module stb_hash_ctrl
  import stb_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [BLK_W-1:0]  msg_data_i,
  input  logic              msg_last_i,
  input  logic [BITS_W-1:0] msg_bits_i,
  output logic              sum_clear_o,
  output logic              sum_valid_o,
  output logic [BLK_W-1:0]  sum_data_o,
  input  logic [BLK_W-1:0]  sigma_i,
  output logic              g_req_o,
  output logic [1:0]        g_mode_o,
  output logic [BLK_W-1:0]  g_data_o,
  output logic [BLK_W-1:0]  g_n_o,
  input  logic              g_done_i,
  output logic              busy_o,
  output logic              done_o
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               full_last_q, full_last_d;

  logic               ready_q, ready_d;
  logic               clear_q, clear_d;
  logic               sum_valid_q, sum_valid_d;
  logic [BLK_W-1:0]   sum_data_q, sum_data_d;
  logic               g_req_q, g_req_d;
  g_mode_t            g_mode_q, g_mode_d;
  logic [BLK_W-1:0]   g_data_q, g_data_d;
  logic [BLK_W-1:0]   g_n_q, g_n_d;
  logic               done_q, done_d;

  logic [BLK_W-1:0]   pad_data;
  logic [PAD_K_W-1:0] pad_k;
  logic [BLK_W-1:0]   pad_out;
  logic               handshake;
  logic               bits_full;
  logic               done_ok;
  logic [BLK_W-1:0]   n_ext;

  // Only the ACCEPT state pads real data; the empty-block path pads zeros at k=0.
  assign pad_data  = (state_q == ACCEPT) ? msg_data_i : '0;
  assign pad_k     = (state_q == ACCEPT) ? msg_bits_i[PAD_K_W-1:0] : '0;

  stb_pad u_pad (
    .data   (pad_data),
    .k      (pad_k),
    .padded (pad_out)
  );

  assign handshake = msg_valid_i && ready_q;
  assign bits_full = (msg_bits_i >= BITS_W'(BLK_W));
  // A completion is only meaningful from the cycle after the request pulse.
  assign done_ok   = g_done_i && !g_req_q;
  assign n_ext     = {{(BLK_W-CNT_W){1'b0}}, n_q};

  // Next-state and next-output logic; every request is registered into the output bank.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    full_last_d = full_last_q;
    ready_d     = 1'b0;
    clear_d     = 1'b0;
    sum_valid_d = 1'b0;
    sum_data_d  = sum_data_q;
    g_req_d     = 1'b0;
    g_mode_d    = g_mode_q;
    g_data_d    = g_data_q;
    g_n_d       = g_n_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = ACCEPT;
          n_d         = '0;
          full_last_d = 1'b0;
          clear_d     = 1'b1;
          ready_d     = 1'b1;
        end
      end

      ACCEPT: begin
        ready_d = 1'b1;
        if (handshake) begin
          ready_d     = 1'b0;
          g_req_d     = 1'b1;
          sum_valid_d = 1'b1;
          g_mode_d    = G_MSG;
          g_n_d       = n_ext;
          if (!msg_last_i || bits_full) begin
            // Full block: no padding inside it; a trailing empty block follows if last.
            g_data_d    = msg_data_i;
            sum_data_d  = msg_data_i;
            n_d         = n_q + CNT_W'(BLK_W);
            full_last_d = msg_last_i;
            state_d     = WAIT_BLK;
          end else begin
            g_data_d    = pad_out;
            sum_data_d  = pad_out;
            n_d         = n_q + CNT_W'(msg_bits_i);
            state_d     = WAIT_PAD;
          end
        end
      end

      WAIT_BLK: begin
        if (done_ok) begin
          if (full_last_q) begin
            state_d     = PAD_EMPTY;
            g_req_d     = 1'b1;
            sum_valid_d = 1'b1;
            g_mode_d    = G_MSG;
            g_data_d    = pad_out;
            sum_data_d  = pad_out;
            g_n_d       = n_ext;
          end else begin
            state_d = ACCEPT;
            ready_d = 1'b1;
          end
        end
      end

      PAD_EMPTY: state_d = WAIT_PAD;

      WAIT_PAD: begin
        if (done_ok) begin
          state_d  = FIN_N;
          g_req_d  = 1'b1;
          g_mode_d = G_FIN_N;
          g_data_d = n_ext;
          g_n_d    = '0;
        end
      end

      FIN_N: state_d = WAIT_N;

      WAIT_N: begin
        if (done_ok) begin
          state_d  = FIN_S;
          g_req_d  = 1'b1;
          g_mode_d = G_FIN_S;
          g_data_d = sigma_i;
          g_n_d    = '0;
        end
      end

      FIN_S: state_d = WAIT_S;

      WAIT_S: begin
        if (done_ok) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered output bank.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      n_q         <= '0;
      full_last_q <= 1'b0;
      ready_q     <= 1'b0;
      clear_q     <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      g_req_q     <= 1'b0;
      g_mode_q    <= G_MSG;
      g_data_q    <= '0;
      g_n_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      n_q         <= n_d;
      full_last_q <= full_last_d;
      ready_q     <= ready_d;
      clear_q     <= clear_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
      g_req_q     <= g_req_d;
      g_mode_q    <= g_mode_d;
      g_data_q    <= g_data_d;
      g_n_q       <= g_n_d;
      done_q      <= done_d;
    end
  end

  assign msg_ready_o = ready_q;
  assign sum_clear_o = clear_q;
  assign sum_valid_o = sum_valid_q;
  assign sum_data_o  = sum_data_q;
  assign g_req_o     = g_req_q;
  assign g_mode_o    = g_mode_q;
  assign g_data_o    = g_data_q;
  assign g_n_o       = g_n_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_stb_hash_ctrl.sv
// Directed bench for the Streebog message-stage sequencer.
module tb_stb_hash_ctrl;
  import stb_pkg::*;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              start_i;
  logic              msg_valid_i;
  logic              msg_ready_o;
  logic [BLK_W-1:0]  msg_data_i;
  logic              msg_last_i;
  logic [BITS_W-1:0] msg_bits_i;
  logic              sum_clear_o;
  logic              sum_valid_o;
  logic [BLK_W-1:0]  sum_data_o;
  logic [BLK_W-1:0]  sigma_i;
  logic              g_req_o;
  logic [1:0]        g_mode_o;
  logic [BLK_W-1:0]  g_data_o;
  logic [BLK_W-1:0]  g_n_o;
  logic              g_done_i;
  logic              busy_o;
  logic              done_o;

  int total = 0;
  int bad   = 0;
  int sum_cnt = 0;

  stb_hash_ctrl dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .msg_valid_i (msg_valid_i),
    .msg_ready_o (msg_ready_o),
    .msg_data_i  (msg_data_i),
    .msg_last_i  (msg_last_i),
    .msg_bits_i  (msg_bits_i),
    .sum_clear_o (sum_clear_o),
    .sum_valid_o (sum_valid_o),
    .sum_data_o  (sum_data_o),
    .sigma_i     (sigma_i),
    .g_req_o     (g_req_o),
    .g_mode_o    (g_mode_o),
    .g_data_o    (g_data_o),
    .g_n_o       (g_n_o),
    .g_done_i    (g_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Count Sigma add strobes away from the active edge.
  always @(negedge clk_i) if (sum_valid_o === 1'b1) sum_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // From a request cycle: wait one cycle, then give a one-cycle g_done_i.
  task automatic finish_g();
    step();
    g_done_i = 1'b1;
    step();
    g_done_i = 1'b0;
  endtask

  task automatic send(input logic [BLK_W-1:0] data, input logic last, input logic [BITS_W-1:0] bits);
    msg_valid_i = 1'b1;
    msg_data_i  = data;
    msg_last_i  = last;
    msg_bits_i  = bits;
    step();
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
  endtask

  logic [BLK_W-1:0] blk_a, blk_b, blk_x, blk_y, sig, ones, exp504;
  int cnt0;
  int unstable;

  initial begin
    blk_a  = {16{32'hDEADBEEF}};
    blk_b  = {16{32'h0BADF00D}};
    blk_x  = {8{64'h0123456789ABCDEF}};
    blk_y  = {8{64'hFEDCBA9876543210}};
    sig    = {8{64'h5A5A_1234_C3C3_9876}};
    ones   = {BLK_W{1'b1}};
    exp504 = {{7{1'b0}}, {505{1'b1}}};

    rstn_i = 1'b0; start_i = 1'b0; msg_valid_i = 1'b0; msg_data_i = '0;
    msg_last_i = 1'b0; msg_bits_i = '0; sigma_i = sig; g_done_i = 1'b0;
    repeat (3) step();
    rstn_i = 1'b1;
    step();

    // Reset state
    check("rst_ctrl", {msg_ready_o, sum_clear_o, sum_valid_o, g_req_o, g_mode_o, busy_o, done_o}, '0);
    check("rst_g_data", g_data_o, '0);
    check("rst_sum_data", sum_data_o, '0);

    // Start: clear pulse and ready
    start_i = 1'b1; step(); start_i = 1'b0;
    check("start_clear", {sum_clear_o, msg_ready_o, busy_o}, 3'b111);

    // Stray start and g_done in ACCEPT are ignored
    start_i = 1'b1; g_done_i = 1'b1; step(); start_i = 1'b0; g_done_i = 1'b0;
    check("stray_ctrl", {sum_clear_o, g_req_o, done_o, sum_valid_o, msg_ready_o, busy_o}, 6'b000011);

    // Backpressure: block X in flight, block Y held valid for 20 cycles
    send(blk_x, 1'b0, 10'd0);
    check("bp_req", {g_req_o, sum_valid_o, msg_ready_o}, 3'b110);
    check("bp_data", g_data_o, blk_x);
    msg_valid_i = 1'b1; msg_data_i = blk_y;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (msg_ready_o !== 1'b0 || g_data_o !== blk_x || g_req_o !== 1'b0) unstable++;
    end
    check("bp_hold", 512'(unstable), '0);
    g_done_i = 1'b1; step(); g_done_i = 1'b0;
    check("bp_ready_back", msg_ready_o, 1'b1);
    step(); msg_valid_i = 1'b0;
    check("bp_y_req", g_req_o, 1'b1);
    check("bp_y_data", g_data_o, blk_y);
    check("bp_y_n", g_n_o, 512'd512);

    // Reset mid-WAIT_BLK
    rstn_i = 1'b0; #1;
    check("midrst_ctrl", {msg_ready_o, sum_clear_o, sum_valid_o, g_req_o, g_mode_o, busy_o, done_o}, '0);
    check("midrst_data", {g_data_o, g_n_o}, '0);
    step(); rstn_i = 1'b1; step();
    check("midrst_idle", {busy_o, done_o, g_req_o}, 3'b000);

    // Empty message after reset
    start_i = 1'b1; step(); start_i = 1'b0;
    check("empty_start", {sum_clear_o, msg_ready_o}, 2'b11);
    send(ones, 1'b1, 10'd0);
    check("empty_req", {g_req_o, sum_valid_o, g_mode_o}, {2'b11, G_MSG});
    check("empty_data", g_data_o, 512'd1);
    check("empty_sum_data", sum_data_o, 512'd1);
    check("empty_n", g_n_o, '0);
    finish_g();
    check("empty_finn_mode", {g_req_o, g_mode_o}, {1'b1, G_FIN_N});
    check("empty_finn_data", g_data_o, '0);
    finish_g();
    check("empty_fins_mode", {g_req_o, g_mode_o}, {1'b1, G_FIN_S});
    check("empty_fins_data", g_data_o, sig);
    check("empty_fins_n", g_n_o, '0);
    sigma_i = '0;
    finish_g();
    check("empty_done", {done_o, busy_o}, 2'b10);
    check("empty_sigma_latched", g_data_o, sig);
    step();
    check("empty_done_pulse", done_o, 1'b0);
    sigma_i = sig;

    // 63-byte message: 504 valid bits
    start_i = 1'b1; step(); start_i = 1'b0;
    send(ones, 1'b1, 10'd504);
    check("b63_data", g_data_o, exp504);
    check("b63_sum_data", sum_data_o, exp504);
    check("b63_n", g_n_o, '0);
    finish_g();
    check("b63_finn_data", g_data_o, 512'd504);
    check("b63_finn_n", g_n_o, '0);
    finish_g();
    finish_g();
    check("b63_done", done_o, 1'b1);

    // Two full blocks, second last with 512 bits, followed by an empty padding block
    start_i = 1'b1; step(); start_i = 1'b0;
    cnt0 = sum_cnt;
    send(blk_a, 1'b0, 10'd0);
    check("two_a_data", g_data_o, blk_a);
    check("two_a_n", g_n_o, '0);
    finish_g();
    check("two_ready", msg_ready_o, 1'b1);
    send(blk_b, 1'b1, 10'd512);
    check("two_b_data", g_data_o, blk_b);
    check("two_b_n", g_n_o, 512'd512);
    finish_g();
    check("two_pad_ctrl", {g_req_o, sum_valid_o, g_mode_o}, {2'b11, G_MSG});
    check("two_pad_data", g_data_o, 512'd1);
    check("two_pad_n", g_n_o, 512'd1024);
    finish_g();
    check("two_finn_data", g_data_o, 512'd1024);
    finish_g();
    finish_g();
    check("two_done", done_o, 1'b1);
    step();
    check("two_sum_strobes", 512'(sum_cnt - cnt0), 512'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
